// File: rtl/branch_resolve_unit_pkg.sv
// Shared processor definitions for branch resolution: opcode, counter and FSM encodings.
package branch_resolve_unit_pkg;

  localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } brs_state_e;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    r = ctr;
    if (taken) begin
      if (ctr != ST) r = ctr + 2'd1;
    end else begin
      if (ctr != SNT) r = ctr - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Branch history table: 2^INDEX_BITS 2-bit saturating counters, one async read, one sync update.
module bht_counter_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int         INDEX_BITS    = 6,
  parameter logic [1:0] COUNTER_RESET = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0][1:0] tbl;

  // Fetch read sees the stored value only; a same-cycle update lands after the edge.
  assign rd_ctr = tbl[rd_idx];

  // Reset every counter, otherwise nudge the resolved entry toward its outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl <= {ENTRIES{COUNTER_RESET}};
    end else if (wr_en) begin
      tbl[wr_idx] <= ctr_step(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches against the fetch prediction; redirects on mispredict,
// trains the BHT and keeps branch/mispredict statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         INDEX_BITS    = 6,
  parameter logic [1:0] COUNTER_RESET = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic        ex_pred_taken,
  input  logic        branch_enable,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  brs_state_e  state_q, state_d;
  logic        resolve;
  logic        mispredict;
  logic [31:0] taken_target;
  logic [31:0] fall_through;
  logic [1:0]  fetch_ctr;

  // While redirecting, the EX slot is being squashed and must not train or count.
  assign resolve      = ex_valid && ex_is_branch && (state_q == IDLE);
  assign mispredict   = branch_enable != ex_pred_taken;
  assign taken_target = ex_pc + ex_imm;
  assign fall_through = ex_pc + 32'd4;
  assign pred_taken   = fetch_ctr[1];

  bht_counter_table #(
    .INDEX_BITS   (INDEX_BITS),
    .COUNTER_RESET(COUNTER_RESET)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_pc[INDEX_BITS+1:2]),
    .rd_ctr  (fetch_ctr),
    .wr_en   (resolve),
    .wr_idx  (ex_pc[INDEX_BITS+1:2]),
    .wr_taken(branch_enable)
  );

  // State register; reset drops any pending redirect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and redirect outputs: REDIRECT is a single-cycle pulse.
  always_comb begin
    state_d        = state_q;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_q)
      IDLE:     if (resolve && mispredict) state_d = REDIRECT;
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        state_d        = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Corrected PC captured on the mispredict edge; held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc <= '0;
    end else if (resolve && mispredict) begin
      redirect_pc <= branch_enable ? taken_target : fall_through;
    end
  end

  // Statistics on every resolve event; both wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (resolve) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed table-driven bench for branch_resolve_unit plus hand sequences for
// squash, saturation, no-bypass and reset-during-redirect.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_imm = '0;
  logic        ex_pred_taken = 1'b0;
  logic        branch_enable = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .ex_valid        (ex_valid),
    .ex_is_branch    (ex_is_branch),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_pred_taken   (ex_pred_taken),
    .branch_enable   (branch_enable),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        be;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
    logic        ptk;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input logic be);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_pred_taken = pred;
    branch_enable = be;
  endtask

  task automatic idle_ex();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
  endtask

  initial begin
    // Counters start at 01; expectations below are cumulative over the table.
    // Index = pc[7:2]; 0x100, 0x200, 0x300 all map to entry 0.
    vt[0] = '{32'h0000_0100, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0,         32'd1, 32'd0, 1'b0};
    vt[1] = '{32'h0000_0100, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, 32'h0000_00F0, 32'd2, 32'd1, 1'b0};
    vt[2] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'd3, 32'd2, 1'b0};
    vt[3] = '{32'h0000_0200, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 32'h0,         32'd4, 32'd2, 1'b1};
    vt[4] = '{32'h0000_0300, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h0,         32'd5, 32'd2, 1'b0};
    vt[5] = '{32'h0000_1004, 32'hFFFF_F000, 1'b1, 1'b0, 1'b1, 32'h0000_1008, 32'd6, 32'd3, 1'b0};

    // Asynchronous reset asserted between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_flush",          {31'b0, flush},          32'd0);
    chk("rst_redirect_pc",    redirect_pc,             32'd0);
    chk("rst_branch_count",   branch_count,            32'd0);
    chk("rst_mis_count",      mispredict_count,        32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 64; i++) begin
      fetch_pc = {24'h0, i[5:0], 2'b00};
      #1;
      chk($sformatf("rst_pred_%0d", i), {31'b0, pred_taken}, 32'd0);
    end

    // Non-branch and invalid EX slots must not count or redirect.
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h100; ex_pred_taken = 1'b0; branch_enable = 1'b1;
    tick();
    ex_valid = 1'b0; ex_is_branch = 1'b1;
    tick();
    idle_ex();
    chk("nonbr_redirect", {31'b0, redirect_valid}, 32'd0);
    chk("nonbr_count",    branch_count,            32'd0);

    // Vector table.
    for (int i = 0; i < 6; i++) begin
      drive_br(vt[i].pc, vt[i].imm, vt[i].pred, vt[i].be);
      tick();
      idle_ex();
      fetch_pc = vt[i].pc;
      #1;
      chk($sformatf("v%0d_redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vt[i].redir});
      chk($sformatf("v%0d_flush", i),          {31'b0, flush},          {31'b0, vt[i].redir});
      chk($sformatf("v%0d_branch_count", i),   branch_count,            vt[i].bc);
      chk($sformatf("v%0d_mis_count", i),      mispredict_count,        vt[i].mc);
      chk($sformatf("v%0d_pred", i),           {31'b0, pred_taken},     {31'b0, vt[i].ptk});
      if (vt[i].redir) begin
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vt[i].rpc);
        tick();
        chk($sformatf("v%0d_pulse_end", i), {31'b0, redirect_valid}, 32'd0);
        chk($sformatf("v%0d_flush_end", i), {31'b0, flush},          32'd0);
        chk($sformatf("v%0d_rpc_hold", i),  redirect_pc,             vt[i].rpc);
      end
    end

    // Squash: branch at 0x40 (entry 16, counter 01) mispredicted taken -> 10.
    drive_br(32'h40, 32'h100, 1'b0, 1'b1);
    tick();
    chk("sq_redirect",   {31'b0, redirect_valid}, 32'd1);
    chk("sq_rpc",        redirect_pc,             32'h140);
    // EX instruction during REDIRECT would decrement and count a mispredict if not squashed.
    drive_br(32'h40, 32'h8, 1'b1, 1'b0);
    tick();
    idle_ex();
    fetch_pc = 32'h40;
    #1;
    chk("sq_pulse_end",  {31'b0, redirect_valid}, 32'd0);
    chk("sq_bc",         branch_count,            32'd7);
    chk("sq_mc",         mispredict_count,        32'd4);
    chk("sq_pred",       {31'b0, pred_taken},     32'd1);
    chk("sq_rpc_hold",   redirect_pc,             32'h140);
    // Three correct taken resolves: 10 -> 11 -> 11 -> 11.
    for (int k = 0; k < 3; k++) begin
      drive_br(32'h40, 32'h100, 1'b1, 1'b1);
      tick();
    end
    idle_ex();
    #1;
    chk("sat_redirect",  {31'b0, redirect_valid}, 32'd0);
    chk("sat_bc",        branch_count,            32'd10);
    chk("sat_pred",      {31'b0, pred_taken},     32'd1);
    // One not-taken: from 11 lands at 10, still predicting taken.
    drive_br(32'h40, 32'h100, 1'b0, 1'b0);
    tick();
    idle_ex();
    #1;
    chk("sat_dec_pred",  {31'b0, pred_taken},     32'd1);
    chk("sat_dec_bc",    branch_count,            32'd11);
    chk("sat_dec_mc",    mispredict_count,        32'd4);

    // Reset during the redirect pulse.
    drive_br(32'h80, 32'h4, 1'b0, 1'b1);
    tick();
    idle_ex();
    chk("mr_pulse",      {31'b0, redirect_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_redirect",   {31'b0, redirect_valid}, 32'd0);
    chk("mr_flush",      {31'b0, flush},          32'd0);
    chk("mr_bc",         branch_count,            32'd0);
    chk("mr_mc",         mispredict_count,        32'd0);
    chk("mr_pred",       {31'b0, pred_taken},     32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_post_%0d", k), {31'b0, redirect_valid}, 32'd0);
    end

    // No bypass: read and update of entry 16 on the same edge.
    fetch_pc = 32'h40;
    drive_br(32'h40, 32'h10, 1'b1, 1'b1);
    #1;
    chk("nb_pre_edge",   {31'b0, pred_taken},     32'd0);
    tick();
    idle_ex();
    chk("nb_post_edge",  {31'b0, pred_taken},     32'd1);
    chk("nb_redirect",   {31'b0, redirect_valid}, 32'd0);
    chk("nb_bc",         branch_count,            32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
